shift_seq_ctrl: RTL and testbench

Command-driven sequencer for a parallel-in/parallel-out register. It accepts one command at a time through a valid/ready handshake. Each command is either a parallel load or a counted multi-cycle shift or rotate. The owning datapath sees the register contents on q and a serial stream on ser_out. It sits between a host/control FSM and the storage register, so callers never toggle load/shift enables directly.

---
 rtl/shift_seq_pkg.sv | 39 +++
 rtl/shift_seq_dp.sv | 30 +++
 rtl/shift_seq_ctrl.sv | 92 +++++++++
 tb/tb_shift_seq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and next-value helper for the shift/rotate sequencer.
package shift_seq_pkg;

  localparam int unsigned MAX_BITS = 64;
  localparam int unsigned IDX_W    = $clog2(MAX_BITS);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_ROTL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // One shift/rotate step on the low w bits of q; bits above w are don't-care.
  function automatic logic [MAX_BITS-1:0] next_q(input op_e op,
                                                 input logic [MAX_BITS-1:0] q,
                                                 input logic ser_in,
                                                 input int unsigned w);
    logic [MAX_BITS-1:0] r;
    r = q;
    case (op)
      OP_SHL:  r = {q[MAX_BITS-2:0], ser_in};
      OP_SHR: begin
        r = q >> 1;
        r[IDX_W'(w - 1)] = ser_in;
      end
      OP_ROTL: r = {q[MAX_BITS-2:0], q[IDX_W'(w - 1)]};
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_seq_dp.sv
// Storage register: parallel load or single-step shift/rotate with serial tap.
module shift_seq_dp
  import shift_seq_pkg::*;
#(
  parameter int unsigned bits = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic            shift_en,
  input  op_e             op,
  input  logic [bits-1:0] d_in,
  input  logic            ser_in,
  output logic [bits-1:0] q,
  output logic            ser_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      ser_out <= 1'b0;
    end else if (load_en) begin
      q <= d_in;
    end else if (shift_en) begin
      q       <= bits'(next_q(op, MAX_BITS'(q), ser_in, bits));
      ser_out <= (op == OP_SHR) ? q[0] : q[bits-1];
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer: accepts load/shift/rotate commands and steps the register.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter  int unsigned bits = 8,
  localparam int unsigned CW   = $clog2(bits) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [CW-1:0]   cmd_cnt,
  input  logic [bits-1:0] d_in,
  input  logic            ser_in,
  output logic [bits-1:0] q,
  output logic            ser_out,
  output logic            busy,
  output logic            done
);

  state_e        state, state_nxt;
  op_e           op_q;
  op_e           cmd_op_e;
  logic [CW-1:0] remaining;
  logic          accept;
  logic          load_en;
  logic          shift_en;

  assign cmd_op_e = op_e'(cmd_op);
  assign accept   = cmd_valid && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latched op and remaining-step counter for the active command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
      op_q      <= OP_LOAD;
    end else if (accept) begin
      remaining <= cmd_cnt;
      op_q      <= cmd_op_e;
    end else if (state == SHIFT) begin
      remaining <= remaining - CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_op_e == OP_LOAD || cmd_cnt == '0) state_nxt = DONE;
          else                                      state_nxt = SHIFT;
        end
      end
      SHIFT:   if (remaining == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_ready is also forced low while reset is held.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    cmd_ready = (state == IDLE) && !rst;
    busy      = (state != IDLE);
    done      = (state == DONE);
    load_en   = accept && (cmd_op_e == OP_LOAD);
    shift_en  = (state == SHIFT);
  end

  shift_seq_dp #(.bits(bits)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .shift_en (shift_en),
    .op       (op_q),
    .d_in     (d_in),
    .ser_in   (ser_in),
    .q        (q),
    .ser_out  (ser_out)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: vector table, corner sequences, random commands.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_cnt = 4'd0;
  logic [7:0] d_in = 8'h00;
  logic       ser_in = 1'b0;
  logic [7:0] q;
  logic       ser_out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq   = 8'h00;
  logic       mout = 1'b0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.bits(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .d_in      (d_in),
    .ser_in    (ser_in),
    .q         (q),
    .ser_out   (ser_out),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  cnt;
    logic [7:0]  d;
    logic [15:0] pat;
    logic [7:0]  exp_q;
    logic        exp_out;
    int          exp_lat;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference step in arithmetic form: doubling/halving on an 8-bit value.
  task automatic model_step(input logic [1:0] op, input logic s);
    int v;
    v = int'(mq);
    case (op)
      2'b01: begin mout = (v >= 128); v = (v * 2 + int'(s)) % 256; end
      2'b10: begin mout = (v % 2) == 1; v = v / 2 + int'(s) * 128; end
      2'b11: begin mout = (v >= 128); v = (v * 2 + (v / 128)) % 256; end
      default: ;
    endcase
    mq = 8'(v);
  endtask

  // Issue one command from a negedge and follow it to completion.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic [7:0] d,
                         input logic [15:0] pat, output int lat);
    int guard;
    int step;
    guard = 0;
    while (!cmd_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    d_in      = d;
    ser_in    = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    if (op == 2'b00) mq = d;
    step = 0;
    while (!done && lat < 20) begin
      check("busy_in_shift", 32'(busy), 32'd1);
      ser_in = pat[4'(step)];
      model_step(op, ser_in);
      step++;
      @(negedge clk);
      lat++;
      check("step_q", 32'(q), 32'(mq));
      check("step_ser_out", 32'(ser_out), 32'(mout));
    end
    check("done_high", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_not_ready", 32'(cmd_ready), 32'd0);
    check("final_q", 32'(q), 32'(mq));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("ready_after_done", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int guard;
    int exp_lat;
    logic [1:0] rop;
    logic [3:0] rcnt;

    vecs[0]  = '{2'b00, 4'd0,  8'h19, 16'h0000, 8'h19, 1'b0, 1};
    vecs[1]  = '{2'b00, 4'd0,  8'h81, 16'h0000, 8'h81, 1'b0, 1};
    vecs[2]  = '{2'b01, 4'd3,  8'h00, 16'hFFFF, 8'h0F, 1'b0, 4};
    vecs[3]  = '{2'b00, 4'd0,  8'hA5, 16'h0000, 8'hA5, 1'b0, 1};
    vecs[4]  = '{2'b11, 4'd8,  8'h00, 16'h0000, 8'hA5, 1'b1, 9};
    vecs[5]  = '{2'b10, 4'd0,  8'h00, 16'h0000, 8'hA5, 1'b1, 1};
    vecs[6]  = '{2'b00, 4'd0,  8'hF0, 16'h0000, 8'hF0, 1'b1, 1};
    vecs[7]  = '{2'b10, 4'd10, 8'h00, 16'h0000, 8'h00, 1'b0, 11};
    vecs[8]  = '{2'b01, 4'd0,  8'h00, 16'h0000, 8'h00, 1'b0, 1};
    vecs[9]  = '{2'b00, 4'd0,  8'h5A, 16'h0000, 8'h5A, 1'b0, 1};
    vecs[10] = '{2'b11, 4'd3,  8'h00, 16'h0000, 8'hD2, 1'b0, 4};
    vecs[11] = '{2'b00, 4'd0,  8'h00, 16'h0000, 8'h00, 1'b0, 1};
    vecs[12] = '{2'b10, 4'd3,  8'h00, 16'h0005, 8'hA0, 1'b0, 4};

    // Reset state, while held and after release.
    @(negedge clk);
    check("rst_q", 32'(q), 32'h0);
    check("rst_ser_out", 32'(ser_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ready_low", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(cmd_ready), 32'h1);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].cnt, vecs[i].d, vecs[i].pat, lat);
      check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d_ser_out", i), 32'(ser_out), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Command held valid through an active SHL 4 is taken only once idle.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = 4'd4; ser_in = 1'b1;
    @(negedge clk);
    cmd_op = 2'b00; d_in = 8'h3C; lat = 1;
    while (!done && lat < 20) begin
      model_step(2'b01, 1'b1);
      @(negedge clk);
      lat++;
    end
    check("held_shl_latency", 32'(lat), 32'd5);
    check("held_shl_q", 32'(q), 32'(mq));
    @(negedge clk);
    check("held_idle_ready", 32'(cmd_ready), 32'd1);
    check("held_load_not_early", 32'(q), 32'(mq));
    @(negedge clk);
    cmd_valid = 1'b0;
    mq = 8'h3C;
    check("held_load_q", 32'(q), 32'h3C);
    check("held_load_done", 32'(done), 32'd1);
    @(negedge clk);

    // Reset mid-shift aborts with no done pulse.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_cnt = 4'd6; ser_in = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_q", 32'(q), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_ready", 32'(cmd_ready), 32'h0);
    check("abort_ser_out", 32'(ser_out), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'h0);
    end
    rst = 1'b0;
    mq = 8'h00;
    mout = 1'b0;
    guard = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) guard++;
    end
    check("abort_no_late_done", 32'(guard), 32'd0);
    check("abort_idle_ready", 32'(cmd_ready), 32'd1);

    // Random commands against the reference model.
    for (int r = 0; r < 60; r++) begin
      rop  = 2'($urandom_range(0, 3));
      rcnt = 4'($urandom_range(0, 15));
      run_cmd(rop, rcnt, 8'($urandom), 16'($urandom), lat);
      exp_lat = (rop == 2'b00 || rcnt == 4'd0) ? 1 : int'(rcnt) + 1;
      check("rand_latency", 32'(lat), 32'(exp_lat));
      check("rand_ser_out", 32'(ser_out), 32'(mout));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
